// File: rtl/scarv_cop_pkg.sv
package scarv_cop_pkg;

  localparam int unsigned SCARV_COP_RSP_W = 39;

  typedef struct packed {
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] wdata;
    logic        exception;
  } scarv_cop_rsp_t;

  // Excepting results never write a GPR and carry no data; rd is kept.
  // A write to x0 is dropped by clearing wen.
  function automatic scarv_cop_rsp_t scarv_cop_sanitize(
    input logic [4:0]  rd,
    input logic        wen,
    input logic [31:0] wdata,
    input logic        exc
  );
    scarv_cop_rsp_t r;
    r.rd        = rd;
    r.exception = exc;
    r.wen       = wen && !exc && (rd != 5'd0);
    r.wdata     = exc ? 32'd0 : wdata;
    return r;
  endfunction

endpackage

// File: rtl/scarv_cop_sync_fifo.sv
module scarv_cop_sync_fifo #(
  parameter int unsigned WIDTH = 39,
  parameter int unsigned DEPTH = 2
) (
  input  logic             g_clk,
  input  logic             g_resetn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wptr[AW-1:0]] <= i_wdata;
        r_wptr                <= r_wptr + (AW+1)'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/scarv_cop_rsp_buf.sv
// Optional zero-latency bypass: SCARV_COP_RSP_BYPASS_EN
module scarv_cop_rsp_buf
  import scarv_cop_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic                         g_clk,
  input  logic                         g_resetn,
  input  logic                         cpu_issue_valid,
  output logic                         cpu_issue_ready,
  input  logic                         ex_rsp_valid,
  output logic                         ex_rsp_ready,
  input  logic [4:0]                   ex_rsp_rd,
  input  logic                         ex_rsp_wen,
  input  logic [31:0]                  ex_rsp_wdata,
  input  logic                         ex_rsp_exception,
  output logic                         cpu_rsp_valid,
  input  logic                         cpu_rsp_ready,
  output logic [4:0]                   cpu_rsp_rd,
  output logic                         cpu_rsp_wen,
  output logic [31:0]                  cpu_rsp_wdata,
  output logic                         cpu_rsp_exception,
  output logic                         cop_idle,
  output logic [$clog2(MAX_OUT+1)-1:0] outstanding
);

  localparam int unsigned CW = $clog2(MAX_OUT+1);

  scarv_cop_rsp_t              w_in;
  scarv_cop_rsp_t              w_head;
  scarv_cop_rsp_t              w_out;
  logic [SCARV_COP_RSP_W-1:0]  w_head_bits;
  logic                        w_full;
  logic                        w_empty;
  logic                        w_push;
  logic                        w_fifo_pop;
  logic                        w_issue;
  logic                        w_rsp_pop;
  logic [CW-1:0]               r_outstanding;

  assign w_in   = scarv_cop_sanitize(ex_rsp_rd, ex_rsp_wen, ex_rsp_wdata, ex_rsp_exception);
  assign w_head = scarv_cop_rsp_t'(w_head_bits);

  assign ex_rsp_ready = !w_full;

`ifdef SCARV_COP_RSP_BYPASS_EN
  logic w_byp;
  // With an empty FIFO the incoming result is presented directly; it is
  // only written to the FIFO if the core does not take it this cycle.
  assign w_byp         = w_empty && ex_rsp_valid;
  assign cpu_rsp_valid = !w_empty || ex_rsp_valid;
  assign w_out         = w_byp ? w_in : w_head;
  assign w_push        = ex_rsp_valid && ex_rsp_ready && !(w_byp && cpu_rsp_ready);
`else
  assign cpu_rsp_valid = !w_empty;
  assign w_out         = w_head;
  assign w_push        = ex_rsp_valid && ex_rsp_ready;
`endif

  assign w_fifo_pop = cpu_rsp_ready && !w_empty;
  assign w_rsp_pop  = cpu_rsp_valid && cpu_rsp_ready;
  assign w_issue    = cpu_issue_valid && cpu_issue_ready;

  assign cpu_rsp_rd        = w_out.rd;
  assign cpu_rsp_wen       = w_out.wen;
  assign cpu_rsp_wdata     = w_out.wdata;
  assign cpu_rsp_exception = w_out.exception;

  scarv_cop_sync_fifo #(
    .WIDTH (SCARV_COP_RSP_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .i_push   (w_push),
    .i_wdata  (w_in),
    .i_pop    (w_fifo_pop),
    .o_rdata  (w_head_bits),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  assign cpu_issue_ready = (r_outstanding != CW'(MAX_OUT));
  assign outstanding     = r_outstanding;
  assign cop_idle        = (r_outstanding == '0) && w_empty;

  // A pop at zero is a protocol error; the count saturates rather than wrapping.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_outstanding <= '0;
    end else if (w_issue && !w_rsp_pop) begin
      r_outstanding <= r_outstanding + CW'(1);
    end else if (!w_issue && w_rsp_pop && (r_outstanding != '0)) begin
      r_outstanding <= r_outstanding - CW'(1);
    end
  end

  a_no_pop_when_zero : assert property (
    @(posedge g_clk) disable iff (!g_resetn) w_rsp_pop |-> (r_outstanding != '0)
  );

endmodule

// File: tb/tb_scarv_cop_rsp_buf.sv
module tb_scarv_cop_rsp_buf;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        cpu_issue_valid;
  logic        cpu_issue_ready;
  logic        ex_rsp_valid;
  logic        ex_rsp_ready;
  logic [4:0]  ex_rsp_rd;
  logic        ex_rsp_wen;
  logic [31:0] ex_rsp_wdata;
  logic        ex_rsp_exception;
  logic        cpu_rsp_valid;
  logic        cpu_rsp_ready;
  logic [4:0]  cpu_rsp_rd;
  logic        cpu_rsp_wen;
  logic [31:0] cpu_rsp_wdata;
  logic        cpu_rsp_exception;
  logic        cop_idle;
  logic [2:0]  outstanding;

  int n_checks = 0;
  int n_errors = 0;

  always #5 g_clk = ~g_clk;

  scarv_cop_rsp_buf #(
    .DEPTH   (2),
    .MAX_OUT (4)
  ) dut (
    .g_clk             (g_clk),
    .g_resetn          (g_resetn),
    .cpu_issue_valid   (cpu_issue_valid),
    .cpu_issue_ready   (cpu_issue_ready),
    .ex_rsp_valid      (ex_rsp_valid),
    .ex_rsp_ready      (ex_rsp_ready),
    .ex_rsp_rd         (ex_rsp_rd),
    .ex_rsp_wen        (ex_rsp_wen),
    .ex_rsp_wdata      (ex_rsp_wdata),
    .ex_rsp_exception  (ex_rsp_exception),
    .cpu_rsp_valid     (cpu_rsp_valid),
    .cpu_rsp_ready     (cpu_rsp_ready),
    .cpu_rsp_rd        (cpu_rsp_rd),
    .cpu_rsp_wen       (cpu_rsp_wen),
    .cpu_rsp_wdata     (cpu_rsp_wdata),
    .cpu_rsp_exception (cpu_rsp_exception),
    .cop_idle          (cop_idle),
    .outstanding       (outstanding)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic issue();
    cpu_issue_valid = 1'b1;
    tick();
    cpu_issue_valid = 1'b0;
  endtask

  task automatic push(input logic [4:0] rd, input logic wen, input logic [31:0] wd, input logic exc);
    ex_rsp_valid     = 1'b1;
    ex_rsp_rd        = rd;
    ex_rsp_wen       = wen;
    ex_rsp_wdata     = wd;
    ex_rsp_exception = exc;
    tick();
    ex_rsp_valid     = 1'b0;
  endtask

  task automatic pop();
    cpu_rsp_ready = 1'b1;
    tick();
    cpu_rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    g_resetn         = 1'b0;
    cpu_issue_valid  = 1'b0;
    ex_rsp_valid     = 1'b0;
    ex_rsp_rd        = '0;
    ex_rsp_wen       = 1'b0;
    ex_rsp_wdata     = '0;
    ex_rsp_exception = 1'b0;
    cpu_rsp_ready    = 1'b0;
    #12;
    chk("rst_idle",        cop_idle, 1);
    chk("rst_rsp_valid",   cpu_rsp_valid, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_issue_ready", cpu_issue_ready, 1);
    chk("rst_ex_ready",    ex_rsp_ready, 1);
    chk("rst_rsp_wdata",   cpu_rsp_wdata, 0);
    chk("rst_rsp_rd",      cpu_rsp_rd, 0);
    @(negedge g_clk);
    g_resetn = 1'b1;
    tick();
    chk("idle_after_rst", cop_idle, 1);

    // Single transaction with 1-cycle latency.
    issue();
    chk("t2_out_1",  outstanding, 1);
    chk("t2_idle_0", cop_idle, 0);
    ex_rsp_valid = 1'b1; ex_rsp_rd = 5'd5; ex_rsp_wen = 1'b1;
    ex_rsp_wdata = 32'hDEADBEEF; ex_rsp_exception = 1'b0;
    chk("t2_no_comb_path", cpu_rsp_valid, 0);
    tick();
    ex_rsp_valid = 1'b0;
    chk("t2_valid", cpu_rsp_valid, 1);
    chk("t2_rd",    cpu_rsp_rd, 5);
    chk("t2_wen",   cpu_rsp_wen, 1);
    chk("t2_wdata", cpu_rsp_wdata, 64'hDEADBEEF);
    chk("t2_exc",   cpu_rsp_exception, 0);
    tick();
    chk("t2_hold_valid", cpu_rsp_valid, 1);
    chk("t2_hold_wdata", cpu_rsp_wdata, 64'hDEADBEEF);
    pop();
    chk("t2_pop_valid", cpu_rsp_valid, 0);
    chk("t2_pop_out",   outstanding, 0);
    chk("t2_pop_idle",  cop_idle, 1);

    // Sanitising.
    issue();
    push(5'd7, 1'b1, 32'h1234, 1'b1);
    chk("t3_exc_rd",    cpu_rsp_rd, 7);
    chk("t3_exc_wen",   cpu_rsp_wen, 0);
    chk("t3_exc_wdata", cpu_rsp_wdata, 0);
    chk("t3_exc_exc",   cpu_rsp_exception, 1);
    pop();
    issue();
    push(5'd0, 1'b1, 32'hABCD, 1'b0);
    chk("t3_x0_wen",   cpu_rsp_wen, 0);
    chk("t3_x0_rd",    cpu_rsp_rd, 0);
    chk("t3_x0_wdata", cpu_rsp_wdata, 64'hABCD);
    pop();
    chk("t3_out_0", outstanding, 0);

    // Fill, backpressure and ordering.
    issue(); issue(); issue();
    chk("t4_out_3", outstanding, 3);
    push(5'd1, 1'b1, 32'h11, 1'b0);
    chk("t4_ready_1", ex_rsp_ready, 1);
    push(5'd2, 1'b1, 32'h22, 1'b0);
    chk("t4_full_ready", ex_rsp_ready, 0);
    ex_rsp_valid = 1'b1; ex_rsp_rd = 5'd3; ex_rsp_wen = 1'b1; ex_rsp_wdata = 32'h33;
    tick();
    chk("t4_still_full", ex_rsp_ready, 0);
    chk("t4_head_1",     cpu_rsp_wdata, 64'h11);
    cpu_rsp_ready = 1'b1;
    tick();
    chk("t4_head_2",     cpu_rsp_wdata, 64'h22);
    chk("t4_ready_back", ex_rsp_ready, 1);
    tick();
    ex_rsp_valid = 1'b0;
    chk("t4_head_3",    cpu_rsp_wdata, 64'h33);
    chk("t4_head_3_rd", cpu_rsp_rd, 3);
    chk("t4_valid_3",   cpu_rsp_valid, 1);
    tick();
    cpu_rsp_ready = 1'b0;
    chk("t4_drained", cpu_rsp_valid, 0);
    chk("t4_out_0",   outstanding, 0);

    // Back-to-back transfers wrap the pointers several times.
    for (int i = 0; i < 10; i++) begin
      cpu_issue_valid = 1'b1;
      cpu_rsp_ready   = 1'b1;
      ex_rsp_valid    = 1'b1;
      ex_rsp_rd       = 5'(i + 1);
      ex_rsp_wen      = 1'b1;
      ex_rsp_wdata    = 32'h100 + 32'(i);
      ex_rsp_exception = 1'b0;
      tick();
      chk("wrap_valid", cpu_rsp_valid, 1);
      chk("wrap_wdata", cpu_rsp_wdata, 64'h100 + 64'(i));
      chk("wrap_out",   outstanding, 1);
    end
    cpu_issue_valid = 1'b0;
    ex_rsp_valid    = 1'b0;
    tick();
    cpu_rsp_ready = 1'b0;
    chk("wrap_end_valid", cpu_rsp_valid, 0);
    chk("wrap_end_out",   outstanding, 0);

    // Outstanding limit and simultaneous issue/pop.
    for (int i = 1; i <= 4; i++) begin
      issue();
      chk("t5_out", outstanding, 64'(i));
    end
    chk("t5_issue_blocked", cpu_issue_ready, 0);
    issue();
    chk("t5_out_sat_4", outstanding, 4);
    push(5'd9, 1'b1, 32'h99, 1'b0);
    pop();
    chk("t5_out_3",      outstanding, 3);
    chk("t5_issue_open", cpu_issue_ready, 1);
    push(5'd10, 1'b1, 32'hAA, 1'b0);
    cpu_issue_valid = 1'b1;
    cpu_rsp_ready   = 1'b1;
    tick();
    cpu_issue_valid = 1'b0;
    cpu_rsp_ready   = 1'b0;
    chk("t5_issue_pop_same", outstanding, 3);
    chk("t5_popped",         cpu_rsp_valid, 0);

    // Asynchronous reset mid-operation.
    push(5'd11, 1'b1, 32'hB1, 1'b0);
    push(5'd12, 1'b1, 32'hB2, 1'b0);
    chk("t6_full",  ex_rsp_ready, 0);
    chk("t6_out_3", outstanding, 3);
    g_resetn = 1'b0;
    #1;
    chk("t6_rst_valid", cpu_rsp_valid, 0);
    chk("t6_rst_out",   outstanding, 0);
    chk("t6_rst_wdata", cpu_rsp_wdata, 0);
    chk("t6_rst_ready", ex_rsp_ready, 1);
    chk("t6_rst_idle",  cop_idle, 1);
    @(negedge g_clk);
    g_resetn = 1'b1;
    tick();
    chk("t6_post_valid", cpu_rsp_valid, 0);

`ifdef SCARV_COP_RSP_BYPASS_EN
    issue();
    cpu_rsp_ready = 1'b1;
    ex_rsp_valid = 1'b1; ex_rsp_rd = 5'd6; ex_rsp_wen = 1'b1;
    ex_rsp_wdata = 32'hCAFE0001; ex_rsp_exception = 1'b0;
    #1;
    chk("byp_valid", cpu_rsp_valid, 1);
    chk("byp_wdata", cpu_rsp_wdata, 64'hCAFE0001);
    chk("byp_rd",    cpu_rsp_rd, 6);
    tick();
    ex_rsp_valid  = 1'b0;
    cpu_rsp_ready = 1'b0;
    #1;
    chk("byp_no_write", cpu_rsp_valid, 0);
    chk("byp_out_0",    outstanding, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
